arbiter_rr4: RTL
================

# arbiter_rr4

Four-requester arbiter that shares one resource, such as the lab display or shared bus, between four clients. Selectable fixed-priority or round-robin policy. Grants are one-hot and registered, with a bounded hold time and a one-cycle release gap between owners. Winner selection reuses the four-input priority-encoding function: highest index wins.

## Interface
- MAX_HOLD, default 8: maximum consecutive grant cycles before forced release; legal range 2..255.
- clk  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req  input  4  request vector, one bit per client; level-sensitive.
- done  input  1  owner finished; sampled only in GRANT.
- rr_en  input  1  1 = round-robin, 0 = fixed priority (req[3] highest).
- gnt  output  4  one-hot grant, registered.
- gnt_id  output  2  binary index of current owner; valid while busy=1.
- busy  output  1  1 while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

## Operation
- Reset values: gnt=4'b0000, gnt_id=2'd0, busy=0, timeout=0, state=IDLE, hold counter=0, last-owner pointer=2'd0.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If |req, latch winner and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - gnt=onehot(owner), busy=1, and the hold counter increments each cycle.
  - Leave for RELEASE on the first of:
    - done=1;
    - req[owner]=0;
    - hold counter reaching MAX_HOLD-1. Set timeout=1 on the RELEASE-entry cycle, only if neither done nor req drop occurred in that same cycle.
- RELEASE:
  - gnt=0, busy=0, and the last-owner pointer updates to owner.
  - Arbitrate in the same cycle: if |req, latch the new winner and go to GRANT; otherwise go to IDLE.
- Fixed mode (rr_en=0): winner is the highest set index of req.
- Round-robin mode (rr_en=1):
  - Search order starts at (last-1) mod 4, descends, and wraps.
  - Example: last=2 gives order 1,0,3,2.
  - With reset pointer 0, the first order is 3,2,1,0, identical to fixed mode.
- Implementation: rotate req by the pointer, encode, then un-rotate the index mod 4.
- rr_en is sampled only at arbitration points (IDLE or RELEASE). A change during GRANT has no effect on the current owner.
- done in IDLE or RELEASE is ignored. Requests from non-owners during GRANT are ignored until RELEASE.
- Hold counter width is ceil(log2(MAX_HOLD)). It clears on GRANT entry and never wraps inside a grant.

## Timing
- Arbitration latency: req sampled at edge t drives gnt from edge t+1 (one cycle).
- Release latency: done or req drop sampled at edge t clears gnt at edge t+1. Exactly one gnt=0 cycle separates two owners.
- Maximum grant length is MAX_HOLD cycles; timeout pulses in the first RELEASE cycle.
- Round-robin fairness: with all four requesting continuously, each client waits at most 3×(MAX_HOLD+1) cycles.
- Reset asserted mid-GRANT: gnt, busy and timeout drop asynchronously without waiting for an edge, and the pointer returns to 0. First arbitration happens on the first edge after reset deasserts.
- gnt, gnt_id, busy and timeout are glitch-free register outputs. No combinational path from req or done to any output.

## Structure
- Shared header arb_defs.vh holds:
  - N_REQ=4;
  - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2;
  - the default MAX_HOLD.
- One sub-module, prio_enc4: combinational, D[3:0] in, X[1:0] and V out, highest index wins, X=0 when V=0. Instantiated once on the rotated request vector.
- Top-level contents: FSM, hold counter, pointer register, rotate/un-rotate logic, output registers.

## Test plan
- Reset: assert reset mid-GRANT (owner 2) -> gnt=0000, busy=0, timeout=0 immediately; after release, req=4'b0001 -> gnt=0001 one cycle later.
- Fixed priority: rr_en=0, req=4'b1010 held, done pulsed each grant -> grants 3, gap, 3, gap, 3. Client 1 is never served.
- Round robin: rr_en=1, req=4'b1111 held, done one cycle after each grant -> gnt_id sequence 3,2,1,0,3 with a single gnt=0 cycle between each.
- Timeout: MAX_HOLD=8, req=4'b0100 held, no done -> gnt=0100 for exactly 8 cycles, timeout=1 for one cycle with gnt=0, then gnt=0100 regranted.
- Request drop: owner 1 deasserts req[1] on grant cycle 3 -> gnt clears next edge, timeout stays 0, pending req[0] is granted after one gap cycle.
- Simultaneous: done=1 on the same cycle the counter hits MAX_HOLD-1 -> release with timeout=0. rr_en toggled mid-grant -> current owner unchanged, and the new policy applies at the next arbitration.

Source files
------------

// File: rtl/arbiter_rr4_pkg.sv
// arbiter_rr4_pkg: shared definitions for the four-client arbiter.
//   N_REQ            number of requesters
//   DEFAULT_MAX_HOLD default grant length limit in cycles
//   state_e          arbiter FSM state encoding
//   onehot4()        binary index to one-hot grant vector
package arbiter_rr4_pkg;

  localparam int unsigned N_REQ            = 4;
  localparam int unsigned DEFAULT_MAX_HOLD = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/arbiter_rr4_if.sv
// arbiter_rr4_if: request/grant bundle between clients and the arbiter.
//   req     client request vector (level)
//   done    owner finished
//   rr_en   1 = round-robin, 0 = fixed priority
//   gnt     one-hot grant
//   gnt_id  binary index of the owner
//   busy    grant active
//   timeout one-cycle pulse on forced release
// Modports: master = client side, slave = arbiter side.
interface arbiter_rr4_if;
  import arbiter_rr4_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic             rr_en;
  logic [N_REQ-1:0] gnt;
  logic [1:0]       gnt_id;
  logic             busy;
  logic             timeout;

  modport master (
    output req, done, rr_en,
    input  gnt, gnt_id, busy, timeout
  );

  modport slave (
    input  req, done, rr_en,
    output gnt, gnt_id, busy, timeout
  );

endinterface

// File: rtl/arbiter_rr4_prio_enc4.sv
// prio_enc4: four-input priority encoder, highest set index wins.
//   d  request vector
//   x  index of the highest set bit (0 when v=0)
//   v  any bit set
module prio_enc4 (
  input  logic [3:0] d,
  output logic [1:0] x,
  output logic       v
);

  always_comb begin
    v = |d;
    x = 2'd0;
    if (d[3])      x = 2'd3;
    else if (d[2]) x = 2'd2;
    else if (d[1]) x = 2'd1;
    else           x = 2'd0;
  end

endmodule

// File: rtl/arbiter_rr4.sv
// arbiter_rr4: four-client arbiter with fixed-priority or round-robin policy,
// registered one-hot grants, MAX_HOLD-bounded ownership and a one-cycle gap
// between owners.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    arbiter_rr4_if.slave (req, done, rr_en in; gnt, gnt_id, busy, timeout out)
module arbiter_rr4
  import arbiter_rr4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic          clk,
  input  logic          reset,
  arbiter_rr4_if.slave  bus
);

  localparam int unsigned      HoldW    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

  state_e           state_q;
  logic [1:0]       owner_q;
  logic [1:0]       ptr_q;
  logic [HoldW-1:0] hold_q;
  logic [N_REQ-1:0] gnt_q;
  logic [1:0]       gnt_id_q;
  logic             busy_q;
  logic             timeout_q;

  logic [1:0]       rot_amt;
  logic [N_REQ-1:0] req_rot;
  logic [1:0]       enc_x;
  logic             enc_v;
  logic [1:0]       winner;

  // In RELEASE the pointer register is only being updated this edge, so the
  // outgoing owner is used directly as the rotation base.
  always_comb begin
    rot_amt = 2'd0;
    if (bus.rr_en) begin
      rot_amt = (state_q == ST_RELEASE) ? owner_q : ptr_q;
    end
  end

  // Rotate right by the pointer so that index (last-1) lands on bit 3, the
  // encoder's top priority; the search then descends and wraps.
  always_comb begin
    req_rot = bus.req;
    unique case (rot_amt)
      2'd0: req_rot = bus.req;
      2'd1: req_rot = {bus.req[0],   bus.req[3:1]};
      2'd2: req_rot = {bus.req[1:0], bus.req[3:2]};
      2'd3: req_rot = {bus.req[2:0], bus.req[3]};
      default: req_rot = bus.req;
    endcase
  end

  prio_enc4 u_enc (
    .d (req_rot),
    .x (enc_x),
    .v (enc_v)
  );

  // Un-rotate: 2-bit addition wraps mod 4.
  assign winner = enc_x + rot_amt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd0;
      hold_q    <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (enc_v) begin
            state_q  <= ST_GRANT;
            owner_q  <= winner;
            hold_q   <= '0;
            gnt_q    <= onehot4(winner);
            gnt_id_q <= winner;
            busy_q   <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (bus.done || !bus.req[owner_q] || (hold_q == HoldLast)) begin
            state_q   <= ST_RELEASE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            // Expiry only counts when the owner was not already leaving.
            timeout_q <= !bus.done && bus.req[owner_q];
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          ptr_q <= owner_q;
          if (enc_v) begin
            state_q  <= ST_GRANT;
            owner_q  <= winner;
            hold_q   <= '0;
            gnt_q    <= onehot4(winner);
            gnt_id_q <= winner;
            busy_q   <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule
